// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: round-robin sharing of the register-file write port
// between the ALU and load paths, plus the decode-stage busy scoreboard.
module wb_port_arbiter #(
    parameter int DATA_W = 19,
    parameter int ADDR_W = 3,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] qry_addr1,
    input  logic [ADDR_W-1:0] qry_addr2,
    output logic              hz1,
    output logic              hz2,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              sb_err
);

    typedef enum logic {
        PICK_REQ0 = 1'b0,
        PICK_REQ1 = 1'b1
    } rr_e;

    rr_e               rr_q, rr_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;
    logic              sb_err_q, sb_err_d;

    logic              grant0, grant1, accept;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;

    always_comb begin
        grant0   = req0_valid && (!req1_valid || rr_q == PICK_REQ0);
        grant1   = req1_valid && !grant0;
        accept   = grant0 || grant1;
        acc_addr = grant0 ? req0_addr : req1_addr;
        acc_data = grant0 ? req0_data : req1_data;
    end

    always_comb begin
        rr_d = rr_q;
        if (grant0) begin
            rr_d = PICK_REQ1;
        end else if (grant1) begin
            rr_d = PICK_REQ0;
        end
    end

    // Writes to r0 complete the handshake but never reach the register file.
    always_comb begin
        wb_we_d   = accept && (acc_addr != '0);
        wb_addr_d = wb_we_d ? acc_addr : wb_addr_q;
        wb_data_d = wb_we_d ? acc_data : wb_data_q;
    end

    // Clear first, then set, so a same-edge reserve of the retiring register wins.
    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (accept) begin
            busy_d[acc_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            if (busy_d[rsv_addr]) begin
                sb_err_d = 1'b1;
            end
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= PICK_REQ0;
            wb_we_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            wb_we_q    <= wb_we_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            sb_err_q   <= sb_err_d;
        end
    end

    always_comb begin
        req0_ready = grant0;
        req1_ready = grant1;
        wb_we      = wb_we_q;
        wb_addr    = wb_addr_q;
        wb_data    = wb_data_q;
        hz1        = busy_q[qry_addr1];
        hz2        = busy_q[qry_addr2];
        busy_cnt   = busy_cnt_q;
        sb_err     = sb_err_q;
    end

endmodule
